ucdp_debounce: RTL and testbench



---
 rtl/ucdp_debounce.sv | 119 +++++++++++
 tb/tb_ucdp_debounce.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucdp_debounce.sv
// ucdp_debounce: glitch/bounce filter for a level that is already synchronous to main_clk_i.
// A change on d_i reaches q_o only after d_i has held the new value for thres_i
// consecutive clock edges. A thres_i of 0 behaves like 1.
// Outputs: the filtered level, a one-cycle edge pulse whose polarity is selected by
// edge_type_p, and a busy flag that is high while a candidate change is being qualified.
// Optional build macro UCDP_DEBOUNCE_GLITCHCNT_EN adds a saturating 8-bit glitch counter
// with a synchronous clear.
module ucdp_debounce #(
   parameter int unsigned cntwidth_p  = 8,
   parameter logic        rstval_p    = 1'b0,
   parameter logic [1:0]  edge_type_p = 2'h0
) (
   input  logic                  main_clk_i,
   input  logic                  main_rst_an_i,
   input  logic [cntwidth_p-1:0] thres_i,
   input  logic                  d_i,
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
   input  logic                  glitch_clr_i,
   output logic [7:0]            glitch_cnt_o,
`endif
   output logic                  q_o,
   output logic                  edge_o,
   output logic                  busy_o
);

   typedef enum logic {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } state_t;

   // Constant 1, one bit wider than the counter, so the compare cannot wrap.
   localparam logic [cntwidth_p:0] one_c = {{cntwidth_p{1'b0}}, 1'b1};

   state_t                state_r;
   logic [cntwidth_p-1:0] cnt_r;
   logic                  q_r;
   logic                  edge_r;

   logic                  change;
   logic [cntwidth_p:0]   thres_eff;
   logic [cntwidth_p:0]   cnt_inc;
   logic                  edge_match;

   assign change     = d_i ^ q_r;
   assign thres_eff  = (thres_i == '0) ? one_c : {1'b0, thres_i};
   assign cnt_inc    = {1'b0, cnt_r} + one_c;
   // q_r still holds the old level: old 0 means a rising edge, old 1 a falling one.
   assign edge_match = (edge_type_p[0] & ~q_r) | (edge_type_p[1] & q_r);

   // Qualification FSM. The filtered level, the edge pulse and the counter are all registered here.
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         state_r <= STABLE;
         cnt_r   <= '0;
         q_r     <= rstval_p;
         edge_r  <= 1'b0;
      end else begin
         edge_r <= 1'b0;
         case (state_r)
            STABLE: begin
               cnt_r <= '0;
               if (change) begin
                  if (thres_eff <= one_c) begin
                     q_r    <= ~q_r;
                     edge_r <= edge_match;
                  end else begin
                     cnt_r   <= one_c[cntwidth_p-1:0];
                     state_r <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (!change) begin
                  // The input fell back before qualifying: drop the candidate change silently.
                  cnt_r   <= '0;
                  state_r <= STABLE;
               end else if (cnt_inc >= thres_eff) begin
                  // Greater-or-equal also covers a threshold lowered below the current count.
                  q_r     <= ~q_r;
                  edge_r  <= edge_match;
                  cnt_r   <= '0;
                  state_r <= STABLE;
               end else begin
                  cnt_r <= cnt_inc[cntwidth_p-1:0];
               end
            end
            default: begin
               cnt_r   <= '0;
               state_r <= STABLE;
            end
         endcase
      end
   end

   assign q_o    = q_r;
   assign edge_o = edge_r;
   assign busy_o = (state_r == CHECK);

`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
   logic       glitch;
   logic [7:0] glitch_cnt_r;

   assign glitch = (state_r == CHECK) & ~change;

   // Saturating glitch counter. The clear wins, and a glitch in the same cycle is then counted as 1.
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         glitch_cnt_r <= 8'h00;
      end else if (glitch_clr_i) begin
         glitch_cnt_r <= glitch ? 8'h01 : 8'h00;
      end else if (glitch && (glitch_cnt_r != 8'hFF)) begin
         glitch_cnt_r <= glitch_cnt_r + 8'h01;
      end
   end

   assign glitch_cnt_o = glitch_cnt_r;
`endif

endmodule

// File: tb/tb_ucdp_debounce.sv
// Directed testbench for ucdp_debounce.
// Four instances share clock, reset, threshold and data:
//   dut_a: edge type 3 (any),     reset value 0
//   dut_r: edge type 1 (rising),  reset value 0
//   dut_f: edge type 2 (falling), reset value 0
//   dut_n: edge type 0 (none),    reset value 1
// Inputs change 1 time unit after a rising edge. Outputs are checked at that same
// point, which is away from the active clock edge.
module tb_ucdp_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] thres;
   logic       d;
   logic       gclr;

   logic q_a, e_a, b_a;
   logic q_r, e_r, b_r;
   logic q_f, e_f, b_f;
   logic q_n, e_n, b_n;
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
   logic [7:0] g_a, g_r, g_f, g_n;
`endif

   int errors = 0;
   int checks = 0;
   int exp_g  = 0;

   always #5 clk = ~clk;

   ucdp_debounce #(.cntwidth_p(8), .rstval_p(1'b0), .edge_type_p(2'h3)) dut_a (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .thres_i(thres), .d_i(d),
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      .glitch_clr_i(gclr), .glitch_cnt_o(g_a),
`endif
      .q_o(q_a), .edge_o(e_a), .busy_o(b_a));

   ucdp_debounce #(.cntwidth_p(8), .rstval_p(1'b0), .edge_type_p(2'h1)) dut_r (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .thres_i(thres), .d_i(d),
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      .glitch_clr_i(gclr), .glitch_cnt_o(g_r),
`endif
      .q_o(q_r), .edge_o(e_r), .busy_o(b_r));

   ucdp_debounce #(.cntwidth_p(8), .rstval_p(1'b0), .edge_type_p(2'h2)) dut_f (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .thres_i(thres), .d_i(d),
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      .glitch_clr_i(gclr), .glitch_cnt_o(g_f),
`endif
      .q_o(q_f), .edge_o(e_f), .busy_o(b_f));

   ucdp_debounce #(.cntwidth_p(8), .rstval_p(1'b1), .edge_type_p(2'h0)) dut_n (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .thres_i(thres), .d_i(d),
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      .glitch_clr_i(gclr), .glitch_cnt_o(g_n),
`endif
      .q_o(q_n), .edge_o(e_n), .busy_o(b_n));

   // Advance one clock edge. The edge-type-0 instance must never pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      checks++;
      if (e_n !== 1'b0) begin
         errors++;
         $display("FAIL edge_none: edge_o=%b want 0", e_n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; d = 1'b0; thres = 8'd4; gclr = 1'b0;
      #22;
      checks++; if (q_a !== 1'b0) begin errors++; $display("FAIL reset_q: q_o=%b want 0", q_a); end
      checks++; if (e_a !== 1'b0) begin errors++; $display("FAIL reset_edge: edge_o=%b want 0", e_a); end
      checks++; if (b_a !== 1'b0) begin errors++; $display("FAIL reset_busy: busy_o=%b want 0", b_a); end
      checks++; if (q_n !== 1'b1) begin errors++; $display("FAIL reset_q_rstval1: q_o=%b want 1", q_n); end
      checks++; if (e_n !== 1'b0) begin errors++; $display("FAIL reset_edge_n: edge_o=%b want 0", e_n); end
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      checks++; if (g_a !== 8'h00) begin errors++; $display("FAIL reset_gcnt: cnt=%0d want 0", g_a); end
`endif
      @(posedge clk); #3; rst_n = 1'b1;
      tick();
      $display("test_reset done q=%b busy=%b", q_a, b_a);
   endtask

   // Rising change with thres 4, then falling change with thres 3.
   task automatic test_rise_fall();
      thres = 8'd4; d = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (q_a !== (k >= 4)) begin errors++; $display("FAIL rise_q k=%0d: q_o=%b want %b", k, q_a, (k >= 4)); end
         checks++; if (b_a !== (k < 4)) begin errors++; $display("FAIL rise_busy k=%0d: busy_o=%b want %b", k, b_a, (k < 4)); end
         checks++; if (e_a !== (k == 4)) begin errors++; $display("FAIL rise_edge_any k=%0d: edge_o=%b want %b", k, e_a, (k == 4)); end
         checks++; if (e_r !== (k == 4)) begin errors++; $display("FAIL rise_edge_rise k=%0d: edge_o=%b want %b", k, e_r, (k == 4)); end
         checks++; if (e_f !== 1'b0) begin errors++; $display("FAIL rise_edge_fall k=%0d: edge_o=%b want 0", k, e_f); end
      end
      tick();
      checks++; if (e_a !== 1'b0) begin errors++; $display("FAIL rise_edge_len: edge_o=%b want 0", e_a); end
      checks++; if (q_a !== 1'b1) begin errors++; $display("FAIL rise_q_hold: q_o=%b want 1", q_a); end
      thres = 8'd3; d = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (q_f !== (k < 3)) begin errors++; $display("FAIL fall_q k=%0d: q_o=%b want %b", k, q_f, (k < 3)); end
         checks++; if (b_f !== (k < 3)) begin errors++; $display("FAIL fall_busy k=%0d: busy_o=%b want %b", k, b_f, (k < 3)); end
         checks++; if (e_f !== (k == 3)) begin errors++; $display("FAIL fall_edge_fall k=%0d: edge_o=%b want %b", k, e_f, (k == 3)); end
         checks++; if (e_a !== (k == 3)) begin errors++; $display("FAIL fall_edge_any k=%0d: edge_o=%b want %b", k, e_a, (k == 3)); end
         checks++; if (e_r !== 1'b0) begin errors++; $display("FAIL fall_edge_rise k=%0d: edge_o=%b want 0", k, e_r); end
      end
      tick();
      checks++; if (e_f !== 1'b0) begin errors++; $display("FAIL fall_edge_len: edge_o=%b want 0", e_f); end
      $display("test_rise_fall done q=%b", q_a);
   endtask

   task automatic test_glitch();
      thres = 8'd4; d = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (b_a !== 1'b1) begin errors++; $display("FAIL glitch_busy k=%0d: busy_o=%b want 1", k, b_a); end
         checks++; if (q_a !== 1'b0) begin errors++; $display("FAIL glitch_q k=%0d: q_o=%b want 0", k, q_a); end
      end
      d = 1'b0;
      tick();
      exp_g++;
      checks++; if (b_a !== 1'b0) begin errors++; $display("FAIL glitch_abort_busy: busy_o=%b want 0", b_a); end
      checks++; if (q_a !== 1'b0) begin errors++; $display("FAIL glitch_abort_q: q_o=%b want 0", q_a); end
      checks++; if (e_a !== 1'b0) begin errors++; $display("FAIL glitch_abort_edge: edge_o=%b want 0", e_a); end
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      checks++; if (g_a !== 8'(exp_g)) begin errors++; $display("FAIL glitch_cnt: cnt=%0d want %0d", g_a, exp_g); end
`endif
      tick();
      checks++; if (e_a !== 1'b0) begin errors++; $display("FAIL glitch_after_edge: edge_o=%b want 0", e_a); end
      $display("test_glitch done q=%b", q_a);
   endtask

   // Thresholds 0 and 1: q_o follows d_i one clock later and busy_o never rises.
   task automatic test_fast();
      logic dprev, qold;
      for (int t = 0; t <= 1; t++) begin
         thres = 8'(t);
         for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) d = ~d;
            dprev = d; qold = q_a;
            tick();
            checks++; if (q_a !== dprev) begin errors++; $display("FAIL fast_q t=%0d i=%0d: q_o=%b want %b", t, i, q_a, dprev); end
            checks++; if (b_a !== 1'b0) begin errors++; $display("FAIL fast_busy t=%0d i=%0d: busy_o=%b want 0", t, i, b_a); end
            checks++; if (e_a !== (dprev != qold)) begin errors++; $display("FAIL fast_edge t=%0d i=%0d: edge_o=%b want %b", t, i, e_a, (dprev != qold)); end
         end
      end
      $display("test_fast done q=%b", q_a);
   endtask

   // With threshold 1, a change on every cycle gives an edge pulse on every cycle.
   task automatic test_back_to_back();
      thres = 8'd1;
      for (int i = 0; i < 4; i++) begin
         d = ~d;
         tick();
         checks++; if (e_a !== 1'b1) begin errors++; $display("FAIL b2b_edge i=%0d: edge_o=%b want 1", i, e_a); end
         checks++; if (q_a !== d) begin errors++; $display("FAIL b2b_q i=%0d: q_o=%b want %b", i, q_a, d); end
      end
      $display("test_back_to_back done q=%b", q_a);
   endtask

   task automatic test_thres_change();
      // Lower the threshold to 3 when cnt has reached 5: toggle on the next edge.
      thres = 8'd10; d = 1'b1;
      for (int k = 1; k <= 5; k++) tick();
      checks++; if (b_a !== 1'b1) begin errors++; $display("FAIL lower_busy: busy_o=%b want 1", b_a); end
      checks++; if (q_a !== 1'b0) begin errors++; $display("FAIL lower_q_pre: q_o=%b want 0", q_a); end
      thres = 8'd3;
      tick();
      checks++; if (q_a !== 1'b1) begin errors++; $display("FAIL lower_q: q_o=%b want 1", q_a); end
      checks++; if (e_a !== 1'b1) begin errors++; $display("FAIL lower_edge: edge_o=%b want 1", e_a); end
      // Raise the threshold from 3 to 6 at cnt 2: toggle on the 6th edge.
      d = 1'b0;
      tick(); tick();
      thres = 8'd6;
      for (int k = 3; k <= 5; k++) begin
         tick();
         checks++; if (q_a !== 1'b1 || b_a !== 1'b1) begin errors++; $display("FAIL raise_hold k=%0d: q_o=%b busy_o=%b want 1 1", k, q_a, b_a); end
      end
      tick();
      checks++; if (q_a !== 1'b0) begin errors++; $display("FAIL raise_q: q_o=%b want 0", q_a); end
      checks++; if (e_a !== 1'b1) begin errors++; $display("FAIL raise_edge: edge_o=%b want 1", e_a); end
      checks++; if (b_a !== 1'b0) begin errors++; $display("FAIL raise_busy: busy_o=%b want 0", b_a); end
      $display("test_thres_change done q=%b", q_a);
   endtask

   task automatic test_reset_mid();
      thres = 8'd4; d = 1'b1;
      tick(); tick();
      checks++; if (b_a !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: busy_o=%b want 1", b_a); end
      rst_n = 1'b0;
      #1;
      checks++; if (b_a !== 1'b0) begin errors++; $display("FAIL rmid_busy: busy_o=%b want 0", b_a); end
      checks++; if (q_a !== 1'b0) begin errors++; $display("FAIL rmid_q: q_o=%b want 0", q_a); end
      checks++; if (q_n !== 1'b1) begin errors++; $display("FAIL rmid_q_rstval1: q_o=%b want 1", q_n); end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (q_a !== 1'b0 || b_a !== 1'b0 || e_a !== 1'b0) begin errors++; $display("FAIL rmid_held: q/busy/edge=%b%b%b want 000", q_a, b_a, e_a); end
      end
      rst_n = 1'b1;
      exp_g = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (q_a !== (k == 4)) begin errors++; $display("FAIL rmid_restart_q k=%0d: q_o=%b want %b", k, q_a, (k == 4)); end
         checks++; if (e_a !== (k == 4)) begin errors++; $display("FAIL rmid_restart_edge k=%0d: edge_o=%b want %b", k, e_a, (k == 4)); end
         checks++; if (b_a !== (k < 4)) begin errors++; $display("FAIL rmid_restart_busy k=%0d: busy_o=%b want %b", k, b_a, (k < 4)); end
      end
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      checks++; if (g_a !== 8'h00) begin errors++; $display("FAIL rmid_gcnt: cnt=%0d want 0", g_a); end
`endif
      $display("test_reset_mid done q=%b", q_a);
   endtask

`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
   task automatic test_glitch_clr();
      // q_a is 1 here. Each glitch is one cycle of d=0 followed by d=1 again.
      thres = 8'd2;
      for (int i = 0; i < 2; i++) begin
         d = 1'b0; tick();
         d = 1'b1; tick();
         exp_g++;
      end
      checks++; if (g_a !== 8'(exp_g)) begin errors++; $display("FAIL gclr_count: cnt=%0d want %0d", g_a, exp_g); end
      d = 1'b0; tick();
      d = 1'b1; gclr = 1'b1; tick(); gclr = 1'b0;
      checks++; if (g_a !== 8'h01) begin errors++; $display("FAIL gclr_same_cycle: cnt=%0d want 1", g_a); end
      gclr = 1'b1; tick(); gclr = 1'b0;
      checks++; if (g_a !== 8'h00) begin errors++; $display("FAIL gclr_clear: cnt=%0d want 0", g_a); end
      $display("test_glitch_clr done cnt=%0d", g_a);
   endtask
`endif

   initial begin
      test_reset();
      test_rise_fall();
      test_glitch();
      test_fast();
      test_back_to_back();
      test_thres_change();
      test_reset_mid();
`ifdef UCDP_DEBOUNCE_GLITCHCNT_EN
      test_glitch_clr();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
